// File: rtl/conv_layer_sequencer.sv
// Descriptor-driven layer scheduler: fetches 6-word descriptors from SDRAM and
// programs, starts and drains the conv controller once per layer.
module conv_layer_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        s_waitrequest,
  output logic [31:0] d_address,
  output logic        d_read,
  input  logic [31:0] d_readdata,
  input  logic        d_waitrequest,
  output logic [2:0]  c_address,
  output logic        c_write,
  output logic        c_read,
  output logic [31:0] c_writedata,
  input  logic [31:0] c_readdata,
  input  logic        c_waitrequest
);

  typedef enum logic [2:0] {IDLE, FETCH, PROG, START, DRAIN, NEXT} state_t;

  state_t      state, state_n;
  logic [2:0]  word, word_n;
  logic [15:0] idx, idx_n;
  logic [15:0] layers_done, ld_n;
  logic [31:0] desc_base;
  logic [15:0] desc_count;
  logic        abort_pending, abort_n;
  logic        done, done_n;
  logic [31:0] desc [6];

  logic        d_read_n, c_write_n, c_read_n;
  logic [31:0] d_addr_n, c_wd_n, desc_sel;
  logic [2:0]  c_addr_n;
  logic        ctrl_wr, busy, d_acc, c_acc;
  logic        unused_c;

  assign unused_c      = ^c_readdata;
  assign s_waitrequest = 1'b0;
  assign busy          = (state != IDLE);
  assign ctrl_wr       = s_write && (s_address == 2'd0);
  assign d_acc         = d_read && !d_waitrequest;
  assign c_acc         = (c_write || c_read) && !c_waitrequest;

  always_comb begin
    s_readdata = '0;
    if (s_read) begin
      unique case (s_address)
        2'd0: s_readdata = {29'd0, done, abort_pending, busy};
        2'd1: s_readdata = desc_base;
        2'd2: s_readdata = {16'd0, desc_count};
        2'd3: s_readdata = {16'd0, layers_done};
      endcase
    end
  end

  always_comb begin
    state_n = state;
    word_n  = word;
    idx_n   = idx;
    ld_n    = layers_done;
    abort_n = abort_pending;
    done_n  = done;
    if (busy && ctrl_wr && s_writedata[1]) abort_n = 1'b1;
    unique case (state)
      IDLE: if (ctrl_wr && s_writedata[0]) begin
        ld_n   = '0;
        done_n = 1'b0;
        if (desc_count == 16'd0) done_n = 1'b1;
        else begin
          state_n = FETCH;
          idx_n   = '0;
          word_n  = '0;
          abort_n = s_writedata[1];
        end
      end
      FETCH: if (d_acc) begin
        if (word == 3'd5) begin
          state_n = PROG;
          word_n  = '0;
        end else word_n = word + 3'd1;
      end
      PROG: if (c_acc) begin
        if (word == 3'd5) begin
          state_n = START;
          word_n  = '0;
        end else word_n = word + 3'd1;
      end
      START: if (c_acc) state_n = DRAIN;
      // read acceptance is held off by the controller until the layer finishes
      DRAIN: if (c_acc) state_n = NEXT;
      NEXT: begin
        ld_n  = layers_done + 16'd1;
        idx_n = idx + 16'd1;
        if ((idx_n == desc_count) || abort_pending) begin
          state_n = IDLE;
          done_n  = 1'b1;
          abort_n = 1'b0;
        end else begin
          state_n = FETCH;
          word_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_comb begin
    desc_sel = '0;
    for (int i = 0; i < 6; i++)
      if (word_n == 3'(i)) desc_sel = desc[i];
    d_read_n  = (state_n == FETCH);
    d_addr_n  = (desc_base + 32'(idx_n) * 32'd6 + 32'(word_n)) << 2;
    c_write_n = (state_n == PROG) || (state_n == START);
    c_read_n  = (state_n == DRAIN);
    c_addr_n  = (state_n == PROG) ? word_n + 3'd1 : 3'd0;
    c_wd_n    = (state_n == PROG)  ? desc_sel :
                (state_n == START) ? 32'd1 : 32'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      word          <= '0;
      idx           <= '0;
      layers_done   <= '0;
      abort_pending <= 1'b0;
      done          <= 1'b0;
      desc_base     <= '0;
      desc_count    <= '0;
      for (int i = 0; i < 6; i++) desc[i] <= '0;
      d_read        <= 1'b0;
      d_address     <= '0;
      c_write       <= 1'b0;
      c_read        <= 1'b0;
      c_address     <= '0;
      c_writedata   <= '0;
    end else begin
      state         <= state_n;
      word          <= word_n;
      idx           <= idx_n;
      layers_done   <= ld_n;
      abort_pending <= abort_n;
      done          <= done_n;
      if (!busy && s_write && s_address == 2'd1) desc_base  <= s_writedata;
      if (!busy && s_write && s_address == 2'd2) desc_count <= s_writedata[15:0];
      for (int i = 0; i < 6; i++)
        if (state == FETCH && d_acc && word == 3'(i)) desc[i] <= d_readdata;
      d_read        <= d_read_n;
      d_address     <= d_addr_n;
      c_write       <= c_write_n;
      c_read        <= c_read_n;
      c_address     <= c_addr_n;
      c_writedata   <= c_wd_n;
    end
  end

endmodule
